// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the 4-stage register/ALU/memory pipeline.
// It arbitrates two requesters round-robin and holds back any request
// that reads a register still in flight. It issues one instruction per cycle.
module pipe_issue_ctrl #(
  parameter int unsigned LAT  = 3,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [23:0]     req0_instr,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [23:0]     req1_instr,
  output logic            req1_ready,
  output logic            iss_valid,
  output logic [3:0]      iss_rs1,
  output logic [3:0]      iss_rs2,
  output logic [3:0]      iss_rd,
  output logic [3:0]      iss_func,
  output logic [7:0]      iss_addr,
  output logic            busy,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_sel_t;

  req_sel_t    rr;
  logic        slot_v  [LAT];
  logic [3:0]  slot_rd [LAT];
  logic        haz0, haz1, ok0, ok1;
  logic        grant0, grant1, accept;
  logic [23:0] acc_instr;

  // The last slot is excluded from the hazard check: it retires on this edge,
  // and its write lands before the dependent instruction reads.
  always_comb begin
    haz0 = 1'b0;
    haz1 = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) begin
      if (slot_v[i]) begin
        if (slot_rd[i] == req0_instr[23:20] || slot_rd[i] == req0_instr[19:16]) haz0 = 1'b1;
        if (slot_rd[i] == req1_instr[23:20] || slot_rd[i] == req1_instr[19:16]) haz1 = 1'b1;
      end
    end
  end

  // Round-robin choice: the preferred requester first, then a fallback to
  // the other one. Both grants are forced low while reset is held.
  always_comb begin
    ok0    = req0_valid & ~haz0;
    ok1    = req1_valid & ~haz1;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (rr == REQ0) begin
        if (ok0)      grant0 = 1'b1;
        else if (ok1) grant1 = 1'b1;
      end else begin
        if (ok1)      grant1 = 1'b1;
        else if (ok0) grant0 = 1'b1;
      end
    end
    accept    = grant0 | grant1;
    acc_instr = grant1 ? req1_instr : req0_instr;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The scoreboard is a shift register of in-flight destinations.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        slot_v[i]  <= 1'b0;
        slot_rd[i] <= '0;
      end
    end else begin
      slot_v[0]  <= accept;
      slot_rd[0] <= acc_instr[15:12];
      for (int unsigned i = 1; i < LAT; i++) begin
        slot_v[i]  <= slot_v[i-1];
        slot_rd[i] <= slot_rd[i-1];
      end
    end
  end

  // busy is high while any slot is valid.
  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) busy = busy | slot_v[i];
  end

  // Issue register, round-robin pointer and the saturating stall counter.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_func  <= '0;
      iss_addr  <= '0;
      rr        <= REQ0;
      stall_cnt <= '0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss_rs1  <= acc_instr[23:20];
        iss_rs2  <= acc_instr[19:16];
        iss_rd   <= acc_instr[15:12];
        iss_func <= acc_instr[11:8];
        iss_addr <= acc_instr[7:0];
        rr       <= grant0 ? REQ1 : REQ0;
      end
      if ((req0_valid | req1_valid) && !accept && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
